// File: rtl/aqfp_rx_deserializer.sv
// AQFP receive deserializer: decodes logicAQFP samples (q0/q1/qZ/qX), assembles WORD_W-bit
// words LSB first and presents them through a valid/ready output register.
module aqfp_rx_deserializer #(
  parameter int unsigned WORD_W    = 8,
  parameter bit          GAP_ABORT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic [1:0]        data_in,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              err_x,
  output logic              overflow,
  output logic [15:0]       word_count
);

  localparam int unsigned CntW = $clog2(WORD_W);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StResync
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                ovf_q, ovf_d;
  logic [15:0]         count_q, count_d;

  // q1=01 and q0=11 carry data (bit value is the inverse of data_in[1]); 00 is a gap, 10 is X.
  logic is_bit, is_gap, is_x, bit_val;
  assign is_bit  = data_in[0];
  assign is_gap  = (data_in == 2'b00);
  assign is_x    = (data_in == 2'b10);
  assign bit_val = ~data_in[1];

  logic              complete;
  logic [WORD_W-1:0] new_word;
  logic              handshake;

  // Next-state: sample decode, word assembly and the output handshake.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    word_d    = word_q;
    valid_d   = valid_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    complete  = 1'b0;
    new_word  = shift_q;
    handshake = valid_q & word_ready;

    if (sample) begin
      if (is_x) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        shift_d = '0;
        state_d = StResync;
      end else if (is_gap) begin
        if (state_q == StResync) begin
          state_d = StIdle;
        end else if (state_q == StCollect && GAP_ABORT) begin
          cnt_d   = '0;
          shift_d = '0;
          state_d = StIdle;
        end
      end else if (is_bit && state_q != StResync) begin
        shift_d[cnt_q] = bit_val;
        if (cnt_q == CntW'(WORD_W - 1)) begin
          complete = 1'b1;
          new_word = shift_d;
          shift_d  = '0;
          cnt_d    = '0;
          state_d  = StIdle;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = StCollect;
        end
      end
    end

    if (handshake) begin
      valid_d = 1'b0;
      count_d = count_q + 16'd1;
    end

    // A completing word may replace the held one only if it is leaving this same cycle.
    if (complete) begin
      if (!valid_q || word_ready) begin
        word_d  = new_word;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = valid_q;
  assign err_x      = err_q;
  assign overflow   = ovf_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_aqfp_rx_deserializer.sv
// Bench: two DUTs (GAP_ABORT=1 as inst0, GAP_ABORT=0 as inst1) share stimulus; a queue-based
// reference model predicts delivered words and flags, a negedge monitor compares.
module tb_aqfp_rx_deserializer;
  localparam int W = 8;
  localparam logic [1:0] Q0 = 2'b11, Q1 = 2'b01, QZ = 2'b00, QX = 2'b10;

  logic clk = 1'b0;
  logic rst, sample, word_ready;
  logic [1:0] data_in;
  logic [W-1:0] wo0, wo1;
  logic wv0, wv1, ex0, ex1, ov0, ov1;
  logic [15:0] wc0, wc1;

  always #5 clk = ~clk;

  aqfp_rx_deserializer #(.WORD_W(W), .GAP_ABORT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .sample(sample), .data_in(data_in), .word_out(wo0),
    .word_valid(wv0), .word_ready(word_ready), .err_x(ex0), .overflow(ov0), .word_count(wc0));

  aqfp_rx_deserializer #(.WORD_W(W), .GAP_ABORT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .sample(sample), .data_in(data_in), .word_out(wo1),
    .word_valid(wv1), .word_ready(word_ready), .err_x(ex1), .overflow(ov1), .word_count(wc1));

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Reference model state per instance.
  bit m_valid [2];
  bit m_err [2];
  bit m_ovf [2];
  bit m_resync [2];
  int m_cnt [2];
  int m_n [2];
  bit m_bits [2][W];
  logic [W-1:0] exp0 [$];
  logic [W-1:0] exp1 [$];

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit comp;
      bit gab;
      logic [W-1:0] w;
      comp = 1'b0;
      w = '0;
      gab = (k == 0);
      if (rst) begin
        m_valid[k] = 0; m_err[k] = 0; m_ovf[k] = 0; m_resync[k] = 0;
        m_cnt[k] = 0; m_n[k] = 0;
        if (k == 0) exp0.delete(); else exp1.delete();
      end else begin
        if (sample) begin
          if (data_in == QX) begin
            m_err[k] = 1; m_n[k] = 0; m_resync[k] = 1;
          end else if (data_in == QZ) begin
            if (m_resync[k]) m_resync[k] = 0;
            else if (gab) m_n[k] = 0;
          end else if (!m_resync[k]) begin
            m_bits[k][m_n[k]] = (data_in == Q1);
            m_n[k]++;
            if (m_n[k] == W) begin
              for (int i = 0; i < W; i++) w[i] = m_bits[k][i];
              comp = 1'b1;
              m_n[k] = 0;
            end
          end
        end
        if (m_valid[k] && word_ready) begin
          m_valid[k] = 0;
          m_cnt[k] = (m_cnt[k] + 1) % 65536;
        end
        if (comp) begin
          if (!m_valid[k]) begin
            m_valid[k] = 1;
            if (k == 0) exp0.push_back(w); else exp1.push_back(w);
          end else begin
            m_ovf[k] = 1;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic mon_inst(input int k, input logic [W-1:0] wo, input logic wv, input logic ex,
                          input logic ov, input logic [15:0] wc);
    logic [W-1:0] e;
    chk("word_valid", k, 32'(wv), 32'(m_valid[k]));
    chk("err_x", k, 32'(ex), 32'(m_err[k]));
    chk("overflow", k, 32'(ov), 32'(m_ovf[k]));
    chk("word_count", k, 32'(wc), 32'(m_cnt[k]));
    if (wv === 1'b1 && word_ready && !rst) begin
      if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
        chk("unexpected_word", k, 32'(wo), 32'hFFFF_FFFF);
      end else begin
        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        chk("word_out", k, 32'(wo), 32'(e));
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      mon_inst(0, wo0, wv0, ex0, ov0, wc0);
      mon_inst(1, wo1, wv1, ex1, ov1, wc1);
    end
  end

  task automatic cyc(input bit s, input logic [1:0] d);
    sample = s;
    data_in = d;
    @(posedge clk);
    #1;
    sample = 1'b0;
    data_in = QZ;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, w[i] ? Q1 : Q0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, QZ);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_wo"}, 0, 32'(wo0), 0);
    chk({name, "_wv"}, 0, 32'(wv0), 0);
    chk({name, "_ex"}, 0, 32'(ex0), 0);
    chk({name, "_ov"}, 0, 32'(ov0), 0);
    chk({name, "_wc"}, 0, 32'(wc0), 0);
    chk({name, "_wo"}, 1, 32'(wo1), 0);
    chk({name, "_wv"}, 1, 32'(wv1), 0);
    chk({name, "_wc"}, 1, 32'(wc1), 0);
  endtask

  logic [1:0] seq_8d [8];

  initial begin
    rst = 1'b1; sample = 1'b0; data_in = QZ; word_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    chk_zero("reset");

    // Basic word 8'h8D with consumer ready.
    seq_8d = '{Q1, Q0, Q1, Q1, Q0, Q0, Q0, Q1};
    word_ready = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, seq_8d[i]);
    chk("w8d_out", 0, 32'(wo0), 32'h8D);
    chk("w8d_valid", 0, 32'(wv0), 1);
    chk("w8d_cnt0", 0, 32'(wc0), 0);
    cyc(1'b0, QZ);
    chk("w8d_valid_drop", 0, 32'(wv0), 0);
    chk("w8d_cnt1", 0, 32'(wc0), 1);

    // Overflow while stalled.
    do_reset();
    word_ready = 1'b0;
    send_word(8'hFF, 8);
    send_word(8'h00, 8);
    chk("ovf_hold", 0, 32'(wo0), 32'hFF);
    chk("ovf_flag", 0, 32'(ov0), 1);
    chk("ovf_flag", 1, 32'(ov1), 1);
    word_ready = 1'b1;
    cyc(1'b0, QZ);
    chk("ovf_cnt", 0, 32'(wc0), 1);
    chk("ovf_valid", 0, 32'(wv0), 0);

    // qX mid-word, resync on qZ, then a clean 8'hA5.
    do_reset();
    word_ready = 1'b1;
    send_word(8'h03, 3);
    cyc(1'b1, QX);
    cyc(1'b1, Q1);
    cyc(1'b1, Q1);
    cyc(1'b1, QZ);
    send_word(8'hA5, 8);
    chk("qx_word", 0, 32'(wo0), 32'hA5);
    chk("qx_word", 1, 32'(wo1), 32'hA5);
    chk("qx_err", 0, 32'(ex0), 1);
    chk("qx_cnt", 0, 32'(wc0), 0);

    // Gap mid-word: aborts in inst0, ignored in inst1.
    do_reset();
    word_ready = 1'b1;
    send_word(8'h05, 4);
    cyc(1'b1, QZ);
    send_word(8'h0C, 4);
    chk("gap0_word", 1, 32'(wo1), 32'hC5);
    chk("gap0_valid", 1, 32'(wv1), 1);
    chk("gap1_pending", 0, 32'(wv0), 0);
    send_word(8'h03, 4);
    chk("gap1_word", 0, 32'(wo0), 32'h3C);
    chk("gap1_valid", 0, 32'(wv0), 1);
    chk("gap0_cnt", 1, 32'(wc1), 1);

    // Completion coinciding with handshake of the previous word.
    do_reset();
    word_ready = 1'b0;
    send_word(8'h12, 8);
    send_word(8'h34, 7);
    word_ready = 1'b1;
    cyc(1'b1, Q0);
    chk("same_valid", 0, 32'(wv0), 1);
    chk("same_word", 0, 32'(wo0), 32'h34);
    chk("same_ovf", 0, 32'(ov0), 0);
    chk("same_cnt", 0, 32'(wc0), 1);

    // Reset while holding a word and mid-word.
    do_reset();
    word_ready = 1'b0;
    send_word(8'h5A, 8);
    send_word(8'h07, 3);
    rst = 1'b1;
    cyc(1'b1, Q1);
    rst = 1'b0;
    chk_zero("midrst");
    word_ready = 1'b1;
    send_word(8'hC3, 8);
    chk("post_rst_word", 0, 32'(wo0), 32'hC3);
    chk("post_rst_valid", 0, 32'(wv0), 1);
    cyc(1'b0, QZ);
    chk("post_rst_cnt", 0, 32'(wc0), 1);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [1:0] d;
      rst = ($urandom_range(0, 99) == 0);
      word_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      if (r == 0) d = QX;
      else if (r == 1) d = QZ;
      else d = $urandom_range(0, 1) ? Q1 : Q0;
      cyc($urandom_range(0, 2) != 0, d);
    end
    rst = 1'b0;
    word_ready = 1'b1;
    for (int n = 0; n < 4; n++) cyc(1'b0, QZ);
    chk("drain", 0, 32'(exp0.size()), 0);
    chk("drain", 1, 32'(exp1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/aqfp_rx_deserializer.md
AQFP_RX_DESERIALIZER -- requirements
Module: aqfp_rx_deserializer

Interface
REQ-001 SHALL have parameter WORD_W, default 8: bits per assembled word, legal range 2..32.
REQ-002 SHALL have parameter GAP_ABORT, default 1: 1 means a qZ sample mid-word discards the partial word; 0 means qZ samples are ignored.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port sample, input, 1: sampling-point strobe, one clk wide; data_in is evaluated only when it is 1.
REQ-006 SHALL have port data_in, input, 2: logicAQFP encoding (q0=2'b11, q1=2'b01, qZ=2'b00, qX=2'b10).
REQ-007 SHALL have port word_out, output, WORD_W: assembled word; the first received bit is in bit 0.
REQ-008 SHALL have port word_valid, output, 1: word_out holds an unconsumed word.
REQ-009 SHALL have port word_ready, input, 1: consumer accepts word_out when word_valid && word_ready.
REQ-010 SHALL have port err_x, output, 1: sticky flag, a qX sample was received.
REQ-011 SHALL have port overflow, output, 1: sticky flag, a completed word was dropped.
REQ-012 SHALL have port word_count, output, 16: count of words accepted by the consumer; wraps modulo 2^16.

Function
REQ-013 SHALL decode data_in only in cycles with sample=1, as follows: q1 -> bit 1; q0 -> bit 0; qZ -> gap; qX -> error.
REQ-014 SHALL implement an FSM with states IDLE (bit count 0), COLLECT (0 < bit count < WORD_W) and RESYNC (discarding samples after a qX).
REQ-015 SHALL move IDLE->COLLECT on a valid bit; WORD_W must be >=2, so a single bit never completes a word.
REQ-016 SHALL shift each valid bit into the shift register at position bit_count and increment bit_count.
REQ-017 SHALL, when the WORD_W-th bit arrives in COLLECT, complete the word, clear bit_count and go to IDLE in the same clock edge.
REQ-018 SHALL assert word_valid and update word_out at the posedge that samples the completing bit (latency 0 cycles after that edge; visible the following cycle).
REQ-019 SHALL hold word_out and word_valid stable until a handshake (word_valid && word_ready); on handshake, drop word_valid and increment word_count.
REQ-020 SHALL, when a completion and a handshake occur in the same cycle, load the new word, keep word_valid at 1, and still increment word_count.
REQ-021 SHALL, when a word completes while word_valid=1 and word_ready=0, keep the held word unchanged, drop the new word and set overflow.
REQ-022 SHALL, on a qZ gap in COLLECT with GAP_ABORT=1, clear bit_count and the shift register and go to IDLE; with GAP_ABORT=0, change no state.
REQ-023 SHALL treat a qZ gap in IDLE as a no-op.
REQ-024 SHALL, on qX in any state, set err_x, clear bit_count and the shift register, and go to RESYNC.
REQ-025 SHALL, in RESYNC, ignore q0, q1 and qX samples and go to IDLE on the first qZ sample.
REQ-026 SHALL leave the output register and the handshake unaffected by qX, RESYNC or gaps; a held word remains deliverable.
REQ-027 SHALL, in cycles with sample=0, change only handshake-related state.
REQ-028 SHALL clear err_x and overflow only through rst.

Reset
REQ-029 SHALL, when rst=1 at posedge clk, set state=IDLE, bit_count=0, shift register=0, word_out=0, word_valid=0, err_x=0, overflow=0 and word_count=0.
REQ-030 SHALL give rst priority over sample and handshake in the same cycle; a partial word or held word is discarded.
REQ-031 SHALL, on the first cycle after rst deasserts, accept a sample.

Verification
REQ-032 Bench SHALL cover, with WORD_W=8 and word_ready=1: samples q1,q0,q1,q1,q0,q0,q0,q1 -> word_out=8'h8D, word_valid high for 1 cycle, word_count=1.
REQ-033 Bench SHALL cover, with word_ready=0: two full words 8'hFF then 8'h00 -> word_out stays 8'hFF, overflow=1; then word_ready=1 -> handshake, word_count=1, word_valid=0.
REQ-034 Bench SHALL cover: 3 bits, then qX, then q1,q1 (ignored), qZ, then 8 bits of 8'hA5 -> err_x=1 and output 8'hA5 only.
REQ-035 Bench SHALL cover, with GAP_ABORT=1: 4 bits, then qZ, then 8 bits 8'h3C -> output 8'h3C. Repeat with GAP_ABORT=0: the 4 bits and the first 4 of the following bits form the first word.
REQ-036 Bench SHALL cover: a completion in the same cycle as a handshake of the previous word -> word_valid remains 1, the new word is loaded, and overflow stays 0.
REQ-037 Bench SHALL cover: rst asserted mid-word and while word_valid=1 -> all outputs 0 next cycle; the subsequent 8 bits form a clean word.
